// File: rtl/tag_pkg.sv
// Shared types and width helpers for the set-associative tag array.
package tag_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } fsm_e;

  // Way-index width; a direct-mapped array still carries a 1-bit way field.
  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  // Tree-PLRU state bits per set (WAYS-1 nodes, minimum one storage bit).
  function automatic int plru_w(input int ways);
    return (ways > 1) ? ways - 1 : 1;
  endfunction

endpackage

// File: rtl/tag_plru.sv
// Tree-PLRU for one set: victim decode (lowest invalid way first) and the
// state that results from marking i_touch most-recently-used.
module tag_plru
  import tag_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int WAY_W = way_w(WAYS),
  parameter int PW    = plru_w(WAYS)
) (
  input  logic [PW-1:0]    i_state,
  input  logic [WAYS-1:0]  i_valid,
  input  logic [WAY_W-1:0] i_touch,
  output logic [WAY_W-1:0] o_victim,
  output logic [PW-1:0]    o_next
);

  logic [WAY_W-1:0] w_plru_vic;
  logic [PW-1:0]    w_next;

  // Each node bit names the subtree holding the next victim (0 = lower half).
  generate
    if (WAYS == 4) begin : g_w4
      always_comb begin
        w_plru_vic = i_state[0] ? {1'b1, i_state[2]} : {1'b0, i_state[1]};
        w_next     = i_state;
        w_next[0]  = ~i_touch[1];
        if (i_touch[1]) w_next[2] = ~i_touch[0];
        else            w_next[1] = ~i_touch[0];
      end
    end else if (WAYS == 2) begin : g_w2
      assign w_plru_vic = i_state;
      assign w_next     = ~i_touch;
    end else begin : g_w1
      logic w_unused;
      assign w_unused   = ^{i_state, i_touch};
      assign w_plru_vic = '0;
      assign w_next     = '0;
    end
  endgenerate

  always_comb begin
    o_victim = w_plru_vic;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!i_valid[w]) o_victim = WAY_W'(w);
    end
  end

  assign o_next = w_next;

endmodule

// File: rtl/tag_array.sv
// Set-associative tag store with 1-cycle lookup, PLRU fill replacement and a
// one-set-per-cycle flush sweep.
module tag_array
  import tag_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int OFFSET_W = 1,
  parameter int INDEX_W  = 4,
  parameter int WAYS     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     lkp_valid,
  input  logic [ADDR_W-1:0]        lkp_addr,
  output logic                     lkp_ready,
  output logic                     rsp_valid,
  output logic                     rsp_hit,
  output logic                     rsp_miss,
  output logic [way_w(WAYS)-1:0]   rsp_way,
  input  logic                     fill_valid,
  input  logic [ADDR_W-1:0]        fill_addr,
  output logic                     fill_ready,
  output logic [way_w(WAYS)-1:0]   fill_way,
  output logic                     fill_done,
  input  logic                     flush_req,
  output logic                     flush_busy
);

  localparam int SETS  = 2**INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WAY_W = way_w(WAYS);
  localparam int PW    = plru_w(WAYS);

  fsm_e                      r_state, w_state_nxt;
  logic [INDEX_W-1:0]        r_flush_idx, w_flush_idx_nxt;
  logic [SETS-1:0][WAYS-1:0] r_valid;
  logic [TAG_W-1:0]          r_tag  [SETS][WAYS];
  logic [PW-1:0]             r_plru [SETS];

  logic                      r_rsp_valid, r_rsp_hit, r_rsp_miss, r_fill_done;
  logic [WAY_W-1:0]          r_rsp_way, r_fill_way;

  logic                      w_idle, w_fill_acc, w_lkp_acc;
  logic [ADDR_W-1:0]         w_addr;
  logic [INDEX_W-1:0]        w_idx;
  logic [TAG_W-1:0]          w_tag;
  logic [WAYS-1:0]           w_set_valid, w_match;
  logic                      w_hit;
  logic [WAY_W-1:0]          w_hit_way, w_plru_vic, w_victim, w_touch;
  logic [PW-1:0]             w_plru_nxt;
  logic                      w_unused;

  // Offset bits never take part in the lookup.
  assign w_unused = ^{lkp_addr, fill_addr};

  assign w_idle     = (r_state == IDLE);
  assign fill_ready = w_idle;
  assign lkp_ready  = w_idle && !fill_valid;
  assign w_fill_acc = fill_valid && fill_ready;
  assign w_lkp_acc  = lkp_valid && lkp_ready;
  assign flush_busy = (r_state == FLUSH);

  // Fill and lookup are never accepted together, so one read port serves both.
  assign w_addr      = fill_valid ? fill_addr : lkp_addr;
  assign w_idx       = w_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign w_tag       = w_addr[ADDR_W-1:OFFSET_W+INDEX_W];
  assign w_set_valid = r_valid[w_idx];

  always_comb begin
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_match[w] = w_set_valid[w] && (r_tag[w_idx][w] == w_tag);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_match[w]) w_hit_way = WAY_W'(w);
    end
  end

  assign w_hit = |w_match;

  // A fill of a resident tag reuses its way so the set never holds duplicates.
  assign w_victim = w_hit ? w_hit_way : w_plru_vic;
  assign w_touch  = w_fill_acc ? w_victim : w_hit_way;

  tag_plru #(
    .WAYS (WAYS)
  ) u_plru (
    .i_state  (r_plru[w_idx]),
    .i_valid  (w_set_valid),
    .i_touch  (w_touch),
    .o_victim (w_plru_vic),
    .o_next   (w_plru_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_flush_idx <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_idx <= w_flush_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_idx_nxt = r_flush_idx;
    case (r_state)
      IDLE: begin
        if (flush_req) begin
          w_state_nxt     = FLUSH;
          w_flush_idx_nxt = '0;
        end
      end
      FLUSH: begin
        w_flush_idx_nxt = r_flush_idx + INDEX_W'(1);
        if (r_flush_idx == INDEX_W'(SETS - 1)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int s = 0; s < SETS; s++) r_plru[s] <= '0;
    end else begin
      if (r_state == FLUSH) r_valid[r_flush_idx] <= '0;
      if (w_fill_acc) begin
        r_valid[w_idx][w_victim] <= 1'b1;
        r_plru[w_idx]            <= w_plru_nxt;
      end else if (w_lkp_acc && w_hit) begin
        r_plru[w_idx]            <= w_plru_nxt;
      end
    end
  end

  // Tag payload needs no reset; valid bits qualify it.
  always_ff @(posedge clk) begin
    if (rst_n && w_fill_acc) r_tag[w_idx][w_victim] <= w_tag;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_hit   <= 1'b0;
      r_rsp_miss  <= 1'b0;
      r_rsp_way   <= '0;
      r_fill_done <= 1'b0;
      r_fill_way  <= '0;
    end else begin
      r_rsp_valid <= w_lkp_acc;
      r_rsp_hit   <= w_lkp_acc && w_hit;
      r_rsp_miss  <= w_lkp_acc && !w_hit;
      r_rsp_way   <= (w_lkp_acc && w_hit) ? w_hit_way : '0;
      r_fill_done <= w_fill_acc;
      if (w_fill_acc) r_fill_way <= w_victim;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_hit   = r_rsp_hit;
  assign rsp_miss  = r_rsp_miss;
  assign rsp_way   = r_rsp_way;
  assign fill_done = r_fill_done;
  assign fill_way  = r_fill_way;

endmodule
